// File: rtl/subleq_mem_if.sv
// Memory/IO bus between the subleq CPU side (master) and the memory responder (slave).
// Groups the CPU bus, the input-port handshake, the output-FIFO handshake and the halt status.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

interface subleq_mem_if #(
    parameter int WORD = `WORD_SIZE
);
    logic [WORD-1:0] addr;
    logic            load;
    logic [WORD-1:0] data_out;
    logic [WORD-1:0] data_in;
    logic            halt;
    logic [WORD-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [WORD-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            cpu_halted;

    modport master (
        output addr, load, data_out, in_data, in_valid, out_ready,
        input  data_in, halt, in_ready, out_data, out_valid, cpu_halted
    );

    modport slave (
        input  addr, load, data_out, in_data, in_valid, out_ready,
        output data_in, halt, in_ready, out_data, out_valid, cpu_halted
    );
endinterface

// File: rtl/subleq_mem_responder.sv
// Bus-slave memory responder for the subleq CPU: word RAM, memory-mapped input port,
// buffered output FIFO and a sticky halt-address flag, with one-cycle registered reads.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module subleq_mem_responder #(
    parameter int WORD           = `WORD_SIZE,
    parameter int RAM_AW         = 8,
    parameter int OUT_DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        areset,
    subleq_mem_if.slave bus
);
    localparam int RAM_WORDS = 1 << RAM_AW;
    localparam int DEPTH     = 1 << OUT_DEPTH_LOG2;

    // The top three addresses of the word space are the I/O and halt locations.
    localparam logic [WORD-1:0] HALT_ADDR = {WORD{1'b1}};
    localparam logic [WORD-1:0] OUT_ADDR  = {{(WORD-2){1'b1}}, 2'b10};
    localparam logic [WORD-1:0] IN_ADDR   = {{(WORD-2){1'b1}}, 2'b01};

    localparam logic [OUT_DEPTH_LOG2:0]   FULL_CNT = {1'b1, {OUT_DEPTH_LOG2{1'b0}}};
    localparam logic [OUT_DEPTH_LOG2:0]   CNT_ONE  = {{OUT_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [OUT_DEPTH_LOG2-1:0] PTR_ONE  = CNT_ONE[OUT_DEPTH_LOG2-1:0];

    logic [WORD-1:0]           ram_r [RAM_WORDS];
    logic [WORD-1:0]           fifo_mem_r [DEPTH];
    logic [OUT_DEPTH_LOG2-1:0] wr_ptr_r;
    logic [OUT_DEPTH_LOG2-1:0] rd_ptr_r;
    logic [OUT_DEPTH_LOG2:0]   count_r;
    logic [WORD-1:0]           data_in_r;
    logic                      cpu_halted_r;

    logic                      is_ram_s;
    logic                      is_in_s;
    logic                      is_out_s;
    logic                      is_halt_s;
    logic                      fifo_full_s;
    logic                      halt_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      ram_we_s;
    logic [RAM_AW-1:0]         ram_idx_s;
    logic [WORD-1:0]           rd_data_s;

    assign is_ram_s    = (bus.addr >> RAM_AW) == {WORD{1'b0}};
    assign is_in_s     = bus.addr == IN_ADDR;
    assign is_out_s    = bus.addr == OUT_ADDR;
    assign is_halt_s   = bus.addr == HALT_ADDR;
    assign ram_idx_s   = bus.addr[RAM_AW-1:0];
    assign fifo_full_s = count_r == FULL_CNT;

    // A stall freezes every side effect of the current bus cycle.
    assign halt_s   = (is_in_s && bus.load && !bus.in_valid) ||
                      (is_out_s && !bus.load && fifo_full_s);
    assign push_s   = is_out_s && !bus.load && !fifo_full_s;
    assign pop_s    = (count_r != {(OUT_DEPTH_LOG2+1){1'b0}}) && bus.out_ready;
    assign ram_we_s = is_ram_s && !bus.load;

    assign bus.halt       = halt_s;
    assign bus.in_ready   = is_in_s && bus.load && bus.in_valid;
    assign bus.data_in    = data_in_r;
    assign bus.out_data   = fifo_mem_r[rd_ptr_r];
    assign bus.out_valid  = count_r != {(OUT_DEPTH_LOG2+1){1'b0}};
    assign bus.cpu_halted = cpu_halted_r;

    // Read-data source select for the addressed location.
    always_comb begin
        rd_data_s = {WORD{1'b0}};
        if (is_ram_s) begin
            rd_data_s = ram_r[ram_idx_s];
        end else if (is_in_s) begin
            rd_data_s = bus.in_data;
        end else begin
            rd_data_s = {WORD{1'b0}};
        end
    end

    // RAM array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= bus.data_out;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= bus.data_out;
        end
    end

    // Registered read data and sticky halt-address flag.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            data_in_r    <= {WORD{1'b0}};
            cpu_halted_r <= 1'b0;
        end else begin
            if (bus.load && !halt_s) begin
                data_in_r <= rd_data_s;
            end
            if (is_halt_s && bus.load) begin
                cpu_halted_r <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; a blocked push never consumes a slot freed this cycle.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_ptr_r <= {OUT_DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {OUT_DEPTH_LOG2{1'b0}};
            count_r  <= {(OUT_DEPTH_LOG2+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_subleq_mem_responder.sv
// Scoreboard bench for subleq_mem_responder: drivers queue expected read data and FIFO words,
// a monitor pops and compares whenever a read completes or the FIFO hands off a word.
module tb_subleq_mem_responder;
    logic clk;
    logic areset;
    int   tests;
    int   fails;

    logic [15:0] rd_q  [$];
    logic [15:0] out_q [$];

    subleq_mem_if #(.WORD(16)) bus ();

    subleq_mem_responder #(.WORD(16), .RAM_AW(8), .OUT_DEPTH_LOG2(2)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: reads complete one edge after an unstalled read; FIFO words leave on valid&&ready.
    always @(posedge clk) begin
        logic        rd_fire;
        logic        pop_fire;
        logic [15:0] pop_word;
        logic [15:0] e;
        rd_fire  = areset && bus.load && !bus.halt;
        pop_fire = areset && bus.out_valid && bus.out_ready;
        pop_word = bus.out_data;
        #1;
        if (rd_fire) begin
            if (rd_q.size() == 0) chk("unexpected_read", {16'h0, bus.data_in}, 32'hDEAD_BEEF);
            else begin
                e = rd_q.pop_front();
                chk("read_data", {16'h0, bus.data_in}, {16'h0, e});
            end
        end
        if (pop_fire) begin
            if (out_q.size() == 0) chk("unexpected_out", {16'h0, pop_word}, 32'hDEAD_BEEF);
            else begin
                e = out_q.pop_front();
                chk("out_data", {16'h0, pop_word}, {16'h0, e});
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic l, input logic [15:0] d);
        @(negedge clk);
        bus.addr = a; bus.load = l; bus.data_out = d;
    endtask

    task automatic idle();
        drive(16'h8000, 1'b0, 16'h0000);
    endtask

    // One bus cycle, held until the responder stops stalling it.
    task automatic xfer(input logic [15:0] a, input logic l, input logic [15:0] d);
        int   n;
        logic h;
        drive(a, l, d);
        n = 0;
        forever begin
            #1;
            h = bus.halt;
            @(posedge clk);
            if (!h) break;
            n++;
            if (n > 50) begin
                chk("xfer_timeout", 32'd1, 32'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp);
        rd_q.push_back(exp);
        xfer(a, 1'b1, 16'h0000);
    endtask

    task automatic wr_out(input logic [15:0] d);
        out_q.push_back(d);
        xfer(16'hFFFE, 1'b0, d);
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.out_valid) break;
        end
        chk(nm, {31'h0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        tests = 0; fails = 0;
        areset = 1'b0;
        bus.addr = 16'h8000; bus.load = 1'b0; bus.data_out = 16'h0;
        bus.in_data = 16'h0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_in", {16'h0, bus.data_in}, 32'h0);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("rst_cpu_halted", {31'h0, bus.cpu_halted}, 32'd0);
        chk("rst_halt", {31'h0, bus.halt}, 32'd0);
        @(negedge clk);
        areset = 1'b1;

        // RAM write/read and data_in hold across a write.
        xfer(16'h0007, 1'b0, 16'h00AA);
        rd(16'h0007, 16'h00AA);
        xfer(16'h0005, 1'b0, 16'h1234);
        #1 chk("write_holds_data_in", {16'h0, bus.data_in}, 32'h0000_00AA);
        rd(16'h0005, 16'h1234);

        // Input port stall for three cycles, then one word consumed.
        drive(16'hFFFD, 1'b1, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("in_stall_halt", {31'h0, bus.halt}, 32'd1);
            chk("in_stall_ready", {31'h0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b1; bus.in_data = 16'h00AB;
        rd_q.push_back(16'h00AB);
        #1;
        chk("in_ready_pulse", {31'h0, bus.in_ready}, 32'd1);
        chk("in_halt_drop", {31'h0, bus.halt}, 32'd0);
        idle();
        bus.in_valid = 1'b0;
        #1 chk("in_ready_low", {31'h0, bus.in_ready}, 32'd0);

        // Output FIFO fill to full, blocked fifth write, then drain.
        wr_out(16'h0011); wr_out(16'h0022); wr_out(16'h0033); wr_out(16'h0044);
        drive(16'hFFFE, 1'b0, 16'h0055);
        out_q.push_back(16'h0055);
        #1 chk("full_out_valid", {31'h0, bus.out_valid}, 32'd1);
        chk("full_halt_0", {31'h0, bus.halt}, 32'd1);
        @(negedge clk);
        #1 chk("full_halt_1", {31'h0, bus.halt}, 32'd1);
        bus.out_ready = 1'b1;
        #1 chk("full_halt_pop_cycle", {31'h0, bus.halt}, 32'd1);
        @(negedge clk);
        #1 chk("retry_unstalled", {31'h0, bus.halt}, 32'd0);
        idle();
        wait_drain("fill_drained");

        // Concurrent push/pop with two entries queued; pointers wrap several times.
        bus.out_ready = 1'b0;
        wr_out(16'h00A0); wr_out(16'h00A1);
        for (int i = 0; i < 10; i++) begin
            drive(16'hFFFE, 1'b0, 16'h00B0 + 16'(i));
            bus.out_ready = 1'b1;
            out_q.push_back(16'h00B0 + 16'(i));
            #1;
            chk("conc_no_halt", {31'h0, bus.halt}, 32'd0);
            chk("conc_valid", {31'h0, bus.out_valid}, 32'd1);
        end
        idle();
        wait_drain("conc_drained");

        // Halt flag and zero-returning addresses.
        rd(16'h0005, 16'h1234);
        #1 chk("halted_before", {31'h0, bus.cpu_halted}, 32'd0);
        rd(16'hFFFF, 16'h0000);
        #1 chk("halted_after", {31'h0, bus.cpu_halted}, 32'd1);
        rd(16'h0007, 16'h00AA);
        rd(16'h8000, 16'h0000);
        rd(16'h0005, 16'h1234);
        rd(16'hFFFE, 16'h0000);

        // Asynchronous reset with three words queued.
        idle();
        bus.out_ready = 1'b0;
        wr_out(16'h00C1); wr_out(16'h00C2); wr_out(16'h00C3);
        rd(16'h0005, 16'h1234);
        idle();
        #2 areset = 1'b0;
        #1;
        chk("async_out_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("async_data_in", {16'h0, bus.data_in}, 32'h0);
        chk("async_cpu_halted", {31'h0, bus.cpu_halted}, 32'd0);
        out_q.delete();
        @(negedge clk);
        areset = 1'b1;
        rd(16'h0005, 16'h1234);
        idle();
        repeat (3) @(negedge clk);
        chk("rd_q_empty", rd_q.size(), 32'd0);
        chk("out_q_empty", out_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/subleq_mem_responder.md
Name: subleq_mem_responder

Overview:
- Bus-slave end of the subleq CPU memory interface. Consumes the CPU's `addr`, `load` and `data_out`, and returns `data_in` with one cycle of read latency.
- Drives the CPU's `halt` input as a stall request.
- Contains a word-addressed RAM, a memory-mapped input port and a buffered output FIFO, both with valid/ready handshakes.
- Sits between the CPU and the board-level I/O in the top-level SoC.

Parameters:
- WORD, `WORD_SIZE, bus word width.
- RAM_AW, 8, RAM address bits. The RAM holds 2^RAM_AW words.
- OUT_DEPTH_LOG2, 2, log2 of output FIFO depth (4 entries).

Ports:
- clk  in  1  system clock, rising edge.
- areset  in  1  asynchronous reset, active-low (0 = reset).
- addr  in  WORD  CPU word address.
- load  in  1  1 = read cycle, 0 = write cycle.
- data_out  in  WORD  CPU write data.
- data_in  out  WORD  registered read data to CPU.
- halt  out  1  stall request to CPU. While it is high, the CPU must hold `addr`, `load` and `data_out`.
- in_data  in  WORD  input port data.
- in_valid  in  1  input word available.
- in_ready  out  1  input word consumed this cycle.
- out_data  out  WORD  head of output FIFO.
- out_valid  out  1  output FIFO non-empty.
- out_ready  in  1  sink accepts head word.
- cpu_halted  out  1  sticky flag: CPU reached its halt address.

Behaviour:
- Address map (M = 2^WORD - 1):
  - addr < 2^RAM_AW: RAM.
  - addr == M-2: IN_ADDR.
  - addr == M-1: OUT_ADDR.
  - addr == M: HALT_ADDR.
  - Any other address is unmapped: reads return 0, writes are ignored.
- Reset (areset low, asynchronous): `data_in` = 0, output FIFO emptied (`out_valid` = 0), `cpu_halted` = 0.
  - RAM contents are not reset.
  - Reset mid-transfer drops any pending push or pop.
- Reads (load = 1, halt = 0):
  - `data_in` takes the addressed value at the next rising edge (latency 1).
  - Read sources: RAM word, `in_data` for IN_ADDR, 0 for OUT_ADDR, 0 for HALT_ADDR, 0 for unmapped.
- Writes (load = 0, halt = 0):
  - RAM address: `mem[addr]` <= `data_out` at the edge.
  - `data_in` holds its value across a write.
- Stall rules:
  - halt = (addr == IN_ADDR && load && !in_valid) || (addr == OUT_ADDR && !load && fifo_full).
  - `halt` is combinational. While it is high, no RAM write, no FIFO push, no input pop, and `data_in` holds.
- Input port:
  - in_ready = (addr == IN_ADDR && load && in_valid).
  - A word transfers on every edge where `in_ready` is high; `data_in` <= `in_data` at that edge.
  - Exactly one word is consumed per read cycle; a held address over N non-stalled cycles consumes N words.
- Output FIFO:
  - Circular buffer of 2^OUT_DEPTH_LOG2 words with wrap-around read and write pointers plus an occupancy count.
  - Push on an edge with addr == OUT_ADDR, !load and !fifo_full.
  - Pop on an edge with out_valid && out_ready.
  - `out_data` = head entry; `out_valid` = count != 0; fifo_full = count == 2^OUT_DEPTH_LOG2.
  - Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
  - When full, the push is blocked even if a pop occurs in the same cycle; it retries next cycle, unstalled.
  - Push into an empty FIFO: `out_valid` rises at the next edge. There is no bypass.
- cpu_halted:
  - Set at the first edge where addr == HALT_ADDR && load.
  - Cleared only by reset.
  - Does not affect RAM or FIFO operation.
- Arithmetic: all address compares are WORD bits wide and unsigned; FIFO pointers wrap modulo depth.

Test Plan:
- RAM read/write (WORD = 16): write 0x1234 to addr 0x0005 with load = 0, then read 0x0005 -> `data_in` = 0x1234 one edge after the read; the write cycle leaves `data_in` at its previous value.
- Input stall: read IN_ADDR (0xFFFD) with in_valid = 0 for 3 cycles, then in_valid = 1 and in_data = 0x00AB -> halt = 1 for 3 cycles; in_ready pulses for one cycle; `data_in` = 0x00AB; halt drops.
- Output FIFO fill: out_ready = 0, write 0x11, 0x22, 0x33, 0x44, 0x55 to OUT_ADDR (0xFFFE) -> first four accepted, halt = 1 on the fifth. Raise out_ready -> drain order 0x11, 0x22, 0x33, 0x44, then 0x55 pushed and drained.
- FIFO concurrency and wrap: 2 entries queued, out_ready = 1, push every cycle for 10 cycles -> count stays at 2, pointers wrap, no halt, data order preserved.
- Halt flag: read 0xFFFF -> cpu_halted = 1 after the edge and `data_in` = 0; unmapped read of 0x8000 -> `data_in` = 0.
- Async reset: assert areset = 0 mid-stream with 3 FIFO entries queued -> out_valid, `data_in` and cpu_halted go to 0 immediately without a clock edge; a RAM word written before reset still reads back its value.
